// File: rtl/shazam_pkg.sv
// Shared constants and types for the spectral-peak output path.
package shazam_pkg;

  localparam int         NUM_MAXIMAS = 16;
  localparam int         MAXIMA_W    = 25;
  localparam int         BIN_W       = 9;
  localparam int         MAG_W       = 16;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 66;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic [MAG_W-1:0] mag;
  } maxima_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND
  } tx_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter: start bit, 8 data bits LSB first, stop bit.
// done pulses in the cycle after the stop bit has run its full length.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       send,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int             CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bits_left;
  logic [8:0]       shreg;

  // Baud down-counter paces each bit; bits_left counts data bits plus stop still to go
  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= 1'b0;
      baud_cnt  <= '0;
      bits_left <= 4'd0;
      shreg     <= '1;
      tx        <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!active) begin
        if (send) begin
          active    <= 1'b1;
          tx        <= 1'b0;
          shreg     <= {1'b1, data};
          bits_left <= 4'd9;
          baud_cnt  <= BAUD_TC;
        end
      end else if (baud_cnt != '0) begin
        baud_cnt <= baud_cnt - 1'b1;
      end else if (bits_left == 4'd0) begin
        active <= 1'b0;
        done   <= 1'b1;
      end else begin
        tx        <= shreg[0];
        shreg     <= {1'b1, shreg[8:1]};
        bits_left <= bits_left - 1'b1;
        baud_cnt  <= BAUD_TC;
      end
    end
  end

  assign ready = ~active;

endmodule

// File: rtl/maxima_uart_tx.sv
// Frames the captured peak set (sync, 4 bytes per entry, XOR checksum)
// and streams it through the byte transmitter.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_IDLE | line idle, waiting for a rising edge of the strobe
//   ST_LOAD | select byte byte_idx, hand it to the byte engine
//   ST_SEND | wait for the byte engine to finish the stop bit
module maxima_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_MAXIMAS  = shazam_pkg::NUM_MAXIMAS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  shazam_pkg::maxima_t [NUM_MAXIMAS-1:0] maximas,
  input  logic                                  maximas_found_active,
  output logic                                  tx,
  output logic                                  busy,
  output logic                                  frame_sent,
  output logic                                  dropped
);
  import shazam_pkg::*;

  localparam logic [6:0] LAST_IDX = 7'(4 * NUM_MAXIMAS + 1);

  tx_state_t                   state, state_nxt;
  maxima_t [NUM_MAXIMAS-1:0]   shadow;
  logic                        mfa_q;
  logic                        capture;
  logic [6:0]                  byte_idx;
  logic [6:0]                  payload_idx;
  logic                        is_payload;
  logic [31:0]                 entry_word;
  logic [7:0]                  payload_byte;
  logic [7:0]                  byte_sel;
  logic [7:0]                  checksum;
  logic                        send;
  logic                        eng_ready;
  logic                        eng_done;

  assign capture     = maximas_found_active & ~mfa_q;
  assign payload_idx = byte_idx - 7'd1;
  assign is_payload  = (byte_idx != 7'd0) && (byte_idx != LAST_IDX);

  // Pick the addressed entry and slice its zero-extended 32-bit word big-endian
  always_comb begin
    entry_word = '0;
    for (int i = 0; i < NUM_MAXIMAS; i++) begin
      if (payload_idx[6:2] == 5'(i)) entry_word = {7'b0, shadow[i]};
    end
    case (payload_idx[1:0])
      2'd0:    payload_byte = entry_word[31:24];
      2'd1:    payload_byte = entry_word[23:16];
      2'd2:    payload_byte = entry_word[15:8];
      default: payload_byte = entry_word[7:0];
    endcase
    if (byte_idx == 7'd0)          byte_sel = SYNC_BYTE;
    else if (byte_idx == LAST_IDX) byte_sel = checksum;
    else                           byte_sel = payload_byte;
  end

  // Next-state and handshake outputs; busy drops in the frame_sent cycle
  always_comb begin
    state_nxt  = state;
    send       = 1'b0;
    frame_sent = 1'b0;
    case (state)
      ST_IDLE: if (capture) state_nxt = ST_LOAD;
      ST_LOAD: if (eng_ready) begin
        send      = 1'b1;
        state_nxt = ST_SEND;
      end
      ST_SEND: if (eng_done) begin
        if (byte_idx == LAST_IDX) begin
          frame_sent = 1'b1;
          state_nxt  = ST_IDLE;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy = (state != ST_IDLE) && !frame_sent;
  end

  // State, edge detect, byte index, running checksum and drop flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      mfa_q    <= 1'b0;
      byte_idx <= 7'd0;
      checksum <= 8'd0;
      dropped  <= 1'b0;
    end else begin
      state   <= state_nxt;
      mfa_q   <= maximas_found_active;
      dropped <= capture && (state != ST_IDLE);
      case (state)
        ST_IDLE: if (capture) begin
          byte_idx <= 7'd0;
          checksum <= 8'd0;
        end
        ST_LOAD: if (send && is_payload) checksum <= checksum ^ byte_sel;
        ST_SEND: if (eng_done && byte_idx != LAST_IDX) byte_idx <= byte_idx + 7'd1;
        default: ;
      endcase
    end
  end

  // Shadow copy is only written when a frame starts, never mid-frame
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && capture) shadow <= maximas;
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .reset(reset),
    .data (byte_sel),
    .send (send),
    .tx   (tx),
    .ready(eng_ready),
    .done (eng_done)
  );

endmodule

// File: tb/tb_maxima_uart_tx.sv
// Directed bench: decodes the UART line and compares frames against hand-built tables.
module tb_maxima_uart_tx;
  import shazam_pkg::*;

  localparam int CPB       = 4;
  localparam int BYTE_CYC  = 10 * CPB + 2;
  localparam int FRAME_CYC = FRAME_BYTES * 10 * CPB + (FRAME_BYTES - 1) * 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mfa = 1'b0;
  logic [15:0][24:0] maximas;
  logic             tx, busy, frame_sent, dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_fr[FRAME_BYTES];
  int   first_start = -1;
  int   sent_cnt = 0, drop_cnt = 0, stop_err = 0, low_cnt = 0, busy_cnt = 0;
  bit   m_active = 1'b0;
  int   m_cnt = 0;
  logic [7:0] m_sh = 8'h00;

  maxima_uart_tx #(.CLKS_PER_BIT(CPB), .NUM_MAXIMAS(16)) dut (
    .clk                 (clk),
    .reset               (reset),
    .maximas             (maximas),
    .maximas_found_active(mfa),
    .tx                  (tx),
    .busy                (busy),
    .frame_sent          (frame_sent),
    .dropped             (dropped)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Line decoder and pulse counters, sampled on the falling edge
  initial forever begin
    @(negedge clk);
    if (reset) begin
      m_active = 1'b0;
    end else begin
      if (frame_sent) sent_cnt++;
      if (dropped) drop_cnt++;
      if (busy) busy_cnt++;
      if (tx !== 1'b1) low_cnt++;
      if (!m_active) begin
        if (tx === 1'b0) begin
          m_active = 1'b1;
          m_cnt = 0;
          if (first_start < 0) first_start = cyc;
        end
      end else begin
        m_cnt++;
        if (m_cnt > CPB && m_cnt < 9 * CPB && (m_cnt % CPB) == CPB / 2)
          m_sh = {tx, m_sh[7:1]};
        else if (m_cnt == 9 * CPB + CPB / 2) begin
          if (tx !== 1'b1) stop_err++;
          rx_q.push_back(m_sh);
          m_active = 1'b0;
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    rx_q.delete();
    first_start = -1;
    sent_cnt = 0;
    drop_cnt = 0;
    stop_err = 0;
    low_cnt  = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_sent();
    int k = 0;
    while (frame_sent !== 1'b1 && k < FRAME_CYC + 200) begin
      tick(1);
      k++;
    end
    if (frame_sent !== 1'b1) check_val("sent_timeout", 0, 1);
  endtask

  task automatic exp_zero();
    for (int i = 0; i < FRAME_BYTES; i++) exp_fr[i] = 8'h00;
    exp_fr[0] = 8'hA5;
  endtask

  task automatic check_frame(input string tag);
    check_val({tag, "_len"}, rx_q.size(), FRAME_BYTES);
    check_val({tag, "_stop"}, stop_err, 0);
    for (int i = 0; i < FRAME_BYTES; i++)
      if (i < rx_q.size()) check_val($sformatf("%s_b%0d", tag, i), rx_q[i], exp_fr[i]);
  endtask

  initial begin
    int f, r, s;
    maximas = '0;
    reset = 1'b1;
    mfa   = 1'b0;
    tick(3);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_sent", frame_sent, 0);
    check_val("rst_drop", dropped, 0);
    reset = 1'b0;
    tick(1);

    // Idle
    mon_clear();
    tick(1000);
    check_val("idle_tx_low", low_cnt, 0);
    check_val("idle_busy", busy_cnt, 0);
    check_val("idle_sent", sent_cnt, 0);
    check_val("idle_drop", drop_cnt, 0);
    check_val("idle_bytes", rx_q.size(), 0);

    // Frame 1: single entry {102, 0x1234}
    maximas[0] = {9'd102, 16'h1234};
    mon_clear();
    mfa = 1'b1;
    check_val("f1_busy_n", busy, 0);
    tick(1);
    check_val("f1_busy_n1", busy, 1);
    check_val("f1_tx_n1", tx, 1);
    tick(1);
    check_val("f1_start_n2", tx, 0);
    mfa = 1'b0;
    wait_sent();
    check_val("f1_time", cyc - first_start, FRAME_CYC);
    check_val("f1_busy_at_sent", busy, 0);
    exp_zero();
    exp_fr[1] = 8'h00; exp_fr[2] = 8'h66; exp_fr[3] = 8'h12; exp_fr[4] = 8'h34;
    exp_fr[65] = 8'h40;
    check_frame("f1");
    tick(1);
    check_val("f1_sent_cnt", sent_cnt, 1);
    check_val("f1_sent_pulse", frame_sent, 0);

    // Frame 2: all maximum, with a dropped edge mid-frame
    for (int i = 0; i < 16; i++) maximas[i] = {9'd511, 16'hFFFF};
    tick(5);
    mon_clear();
    mfa = 1'b1;
    tick(1);
    mfa = 1'b0;
    tick(500);
    maximas = '0;
    maximas[3] = {9'd300, 16'hBEEF};
    mfa = 1'b1;
    tick(1);
    check_val("f2_dropped", dropped, 1);
    tick(1);
    check_val("f2_dropped_clr", dropped, 0);
    mfa = 1'b0;
    wait_sent();
    f = cyc;
    check_val("f2_time", cyc - first_start, FRAME_CYC);
    check_val("f2_drop_cnt", drop_cnt, 1);
    exp_zero();
    for (int e = 0; e < 16; e++) begin
      exp_fr[1 + 4*e] = 8'h01; exp_fr[2 + 4*e] = 8'hFF;
      exp_fr[3 + 4*e] = 8'hFF; exp_fr[4 + 4*e] = 8'hFF;
    end
    exp_fr[65] = 8'h00;
    check_frame("f2");

    // Frame 3: edge one cycle after frame_sent
    mon_clear();
    tick(1);
    mfa = 1'b1;
    tick(1);
    check_val("f3_busy", busy, 1);
    check_val("f3_tx_load", tx, 1);
    tick(1);
    check_val("f3_start", tx, 0);

    // Reset during the start bit of byte 30, strobe held high across release
    s = f + 3;
    while (cyc < s + 30 * BYTE_CYC + 1) tick(1);
    check_val("f3_b30_start", tx, 0);
    reset = 1'b1;
    tick(1);
    check_val("mid_rst_tx", tx, 1);
    check_val("mid_rst_busy", busy, 0);
    check_val("mid_rst_sent", frame_sent, 0);
    check_val("mid_rst_drop", dropped, 0);
    mon_clear();
    reset = 1'b0;
    r = cyc;
    tick(1);
    check_val("rel_busy", busy, 1);
    check_val("rel_tx_load", tx, 1);
    tick(1);
    check_val("rel_start", tx, 0);
    wait_sent();
    check_val("f4_first_start", first_start, r + 2);
    check_val("f4_time", cyc - (r + 2), FRAME_CYC);
    exp_zero();
    exp_fr[13] = 8'h01; exp_fr[14] = 8'h2C; exp_fr[15] = 8'hBE; exp_fr[16] = 8'hEF;
    exp_fr[65] = 8'h7C;
    check_frame("f4");
    check_val("f4_drop_cnt", drop_cnt, 0);

    // Frame 5: strobe held high for 100 cycles
    mfa = 1'b0;
    tick(5);
    mon_clear();
    mfa = 1'b1;
    tick(100);
    mfa = 1'b0;
    wait_sent();
    check_frame("f5");
    tick(50);
    check_val("f5_sent_cnt", sent_cnt, 1);
    check_val("f5_drop_cnt", drop_cnt, 0);
    check_val("f5_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
